icache_l1: RTL
==============

# icache_l1

Direct-mapped L1 instruction cache sitting between the IFU fetch port and the `icache_axi` refill engine. It returns one 32-bit instruction per accepted fetch. On a hit the instruction comes from its internal line array. On a miss it issues one 32-byte line request on the L2 interface, installs the returned 8-word line, and then replays the lookup. It also handles `fence.i` invalidation.

## Interface
- `SETS`, 64, number of lines; power of two ≥2. Index width `IW = log2(SETS)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ifu_req`  in  1  fetch request.
- `ifu_addr`  in  64  fetch byte address; bits [1:0] ignored.
- `ifu_ready`  out  1  cache can accept a request this cycle.
- `icache_rvalid`  out  1  single-cycle pulse: `icache_rdata` is valid.
- `icache_rdata`  out  32  instruction.
- `fence_i`  in  1  invalidate-all request (pulse).
- `icache_l2_rreq`  out  1  single-cycle line-request pulse.
- `icache_l2_raddr`  out  64  line address; 32-byte aligned.
- `l2_icache_rdata`  in  8x32  returned line; word i = bytes base+4i.
- `l2_icache_rask`  in  1  single-cycle pulse: line data valid.
- `perf_hit`  out  64  hit counter (see Configuration).
- `perf_miss`  out  64  miss counter (see Configuration).

## Operation
- Address split:
  - offset = `addr[4:0]`; word select = `addr[4:2]`.
  - index = `addr[4+IW:5]`.
  - tag = `addr[63:5+IW]`.
- Storage: `SETS` x {valid, tag, 8x32 data}, built from flops. Reads are combinational from the registered request address.
- States: IDLE, LOOKUP, MISS, REFILL.
  - IDLE: `ifu_ready`=1 unless a flush is pending. `ifu_req`&`ifu_ready` latches the address and moves to LOOKUP.
  - LOOKUP: hit = valid & tag match. On hit: pulse `icache_rvalid` with the selected word, count a hit, go to IDLE. On miss: count a miss, go to MISS, and drive the `icache_l2_rreq` pulse in the first MISS cycle.
  - MISS: `icache_l2_raddr` = latched address & ~64'h1F, held stable until `l2_icache_rask`. `icache_l2_rreq` is never re-asserted within one miss. On `l2_icache_rask`, capture the line and go to REFILL.
  - REFILL: write data and tag, set valid, go to LOOKUP. The replay hits and responds.
- `fence_i`:
  - Latched into a pending flag in any state.
  - The flag clears all valid bits in the next IDLE cycle. It takes one cycle, then the flag clears.
  - While the flag is pending, `ifu_ready`=0.
  - `fence_i` and `ifu_req` together in IDLE: the flush wins and the request is not accepted.
  - `fence_i` during MISS/REFILL: the in-flight fetch completes and responds first, then the flush is applied.
- No back-pressure on the response. The IFU must consume `icache_rvalid` in the cycle it is asserted.
- The whole line is refilled regardless of word select. No critical-word-first.

## Timing
- Reset values: state IDLE, all valid bits 0, flush pending 0, `ifu_ready`=0 during reset then 1, `icache_rvalid`=0, `icache_rdata`=0, `icache_l2_rreq`=0, `icache_l2_raddr`=0, counters 0.
- Hit: request accepted at edge T. `icache_rvalid` is high in cycle T+1. `ifu_ready` is high again at T+2. Throughput is one fetch per 2 cycles.
- Miss:
  - Accept at T; LOOKUP at T+1.
  - `icache_l2_rreq` is high in cycle T+2 only.
  - `l2_icache_rask` arrives at cycle R; REFILL is at R+1; LOOKUP/`icache_rvalid` is at R+2.
- `icache_l2_rreq` must be low in the cycle `l2_icache_rask` is high and the cycle after. This prevents the downstream engine from restarting.
- Reset mid-miss: return to IDLE immediately, drop the outstanding request, and ignore any `l2_icache_rask` that arrives outside MISS.
- Index/tag widths track `SETS`. The counters wrap modulo 2^64.

## Configuration
- `ICACHE_PERF_EN` defined: `perf_hit`/`perf_miss` increment once per LOOKUP hit/miss. A replay after REFILL counts as a hit.
- Not defined: the counter logic is not built; `perf_hit`/`perf_miss` are tied to 0. Functional behaviour is otherwise identical.

## Test plan
- Cold fetch `0x8000_0004`:
  - One `icache_l2_rreq` pulse with `icache_l2_raddr`=`0x8000_0000`.
  - L2 returns words `0x1000+i`.
  - `icache_rvalid` fires 2 cycles after `l2_icache_rask` with `icache_rdata`=`0x1001`.
- Same-line hit: after the above, fetch `0x8000_001C` -> `icache_rvalid` in the next cycle with `0x1007`, and no `icache_l2_rreq`.
- Conflict: fetch `0x8000_0000`, then `0x8000_0800` (same index at SETS=64) -> second is a miss and refills. Refetching `0x8000_0000` misses again.
- Flush: warm line at `0x8000_0000`, pulse `fence_i` together with `ifu_req` -> request not accepted, `ifu_ready` low 1 cycle. The subsequent fetch misses.
- `fence_i` during MISS: the pending fetch still responds with correct data. The next fetch to the same line misses.
- Reset while MISS with L2 latency 10: assert `rst` at cycle 3 -> `icache_l2_rreq`=0, IDLE, late `l2_icache_rask` ignored. With `ICACHE_PERF_EN`, the counters read 0.

Source files
------------

// File: rtl/icache_l1_if.sv
// Fetch-side and L2-refill-side signals of the L1 instruction cache.
// slave = cache side, master = IFU / refill-engine side.
interface icache_l1_if;
  logic            ifu_req;
  logic [63:0]     ifu_addr;
  logic            ifu_ready;
  logic            icache_rvalid;
  logic [31:0]     icache_rdata;
  logic            fence_i;
  logic            icache_l2_rreq;
  logic [63:0]     icache_l2_raddr;
  logic [7:0][31:0] l2_icache_rdata;
  logic            l2_icache_rask;

  modport master (
    output ifu_req, ifu_addr, fence_i, l2_icache_rdata, l2_icache_rask,
    input  ifu_ready, icache_rvalid, icache_rdata, icache_l2_rreq, icache_l2_raddr
  );

  modport slave (
    input  ifu_req, ifu_addr, fence_i, l2_icache_rdata, l2_icache_rask,
    output ifu_ready, icache_rvalid, icache_rdata, icache_l2_rreq, icache_l2_raddr
  );
endinterface

// File: rtl/icache_l1.sv
// Direct-mapped L1 I-cache, 8-word lines, fence.i flush; perf counters under ICACHE_PERF_EN.
// Hit responds 1 cycle after accept, miss 2 cycles after L2 return; no response backpressure, one fetch in flight.
module icache_l1 #(
  parameter int SETS = 64
) (
  input  logic        clk,
  input  logic        rst,
  icache_l1_if.slave  bus,
  output logic [63:0] perf_hit,
  output logic [63:0] perf_miss
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 59 - IW;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} state_t;
  typedef logic [7:0][31:0] line_t;

  state_t          state_q, state_d;
  logic [63:0]     req_addr_q;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q [SETS];
  line_t           data_q [SETS];
  line_t           line_buf_q;
  logic            flush_q;
  logic            rreq_q;

  logic [IW-1:0]   idx;
  logic [TW-1:0]   tag;
  logic [2:0]      wsel;
  logic            hit;
  logic            accept;
  logic            unused_lsb;

  assign idx        = req_addr_q[4+IW:5];
  assign tag        = req_addr_q[63:5+IW];
  assign wsel       = req_addr_q[4:2];
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_lsb = ^req_addr_q[1:0];

  always_comb begin
    state_d              = state_q;
    accept               = 1'b0;
    bus.ifu_ready        = 1'b0;
    bus.icache_rvalid    = 1'b0;
    bus.icache_rdata     = '0;
    bus.icache_l2_raddr  = '0;
    case (state_q)
      IDLE: begin
        bus.ifu_ready = !flush_q;
        // A fence arriving alongside a request wins; the request must retry.
        accept = bus.ifu_req && !flush_q && !bus.fence_i;
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          bus.icache_rvalid = 1'b1;
          bus.icache_rdata  = data_q[idx][wsel];
          state_d           = IDLE;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        bus.icache_l2_raddr = {req_addr_q[63:5], 5'b0};
        if (bus.l2_icache_rask) state_d = REFILL;
      end
      REFILL:  state_d = LOOKUP;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      accept              = 1'b0;
      bus.ifu_ready       = 1'b0;
      bus.icache_rvalid   = 1'b0;
      bus.icache_rdata    = '0;
      bus.icache_l2_raddr = '0;
    end
  end

  // Request pulse comes from a register so it lands only in the first MISS cycle.
  assign bus.icache_l2_rreq = rreq_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      valid_q    <= '0;
      flush_q    <= 1'b0;
      rreq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rreq_q  <= (state_q == LOOKUP) && !hit;
      if (accept) req_addr_q <= bus.ifu_addr;
      if (state_q == IDLE && flush_q) begin
        valid_q <= '0;
        flush_q <= bus.fence_i;
      end else begin
        if (bus.fence_i) flush_q <= 1'b1;
        if (state_q == REFILL) valid_q[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == MISS && bus.l2_icache_rask) line_buf_q <= bus.l2_icache_rdata;
    if (state_q == REFILL) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= line_buf_q;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) perf_hit  <= perf_hit + 64'd1;
      else     perf_miss <= perf_miss + 64'd1;
    end
  end
`else
  assign perf_hit  = '0;
  assign perf_miss = '0;
`endif

endmodule
